// File: rtl/wb_bytemask_seq_pkg.sv
// Shared defaults and lane helpers for the activation-SRAM write-back generator.
// The RTL and its bench both import this package.
package wb_bytemask_seq_pkg;

  localparam int DEF_CH_NUM       = 24;
  localparam int DEF_ACT_PER_ADDR = 4;
  localparam int DEF_BW_PER_ACT   = 16;
  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_LATENCY      = 5;

  localparam int CH_W   = $clog2(DEF_CH_NUM);
  localparam int ACT_W  = $clog2(DEF_ACT_PER_ADDR);
  localparam int MASK_W = DEF_CH_NUM * DEF_ACT_PER_ADDR;

  // Lane 0 is the most significant mask bit and the most significant data slice.
  function automatic int lane_to_mask_bit(input int lane, input int mask_w);
    return mask_w - 1 - lane;
  endfunction

endpackage

// File: rtl/wb_bytemask_seq_if.sv
// Activation input bus and SRAM write port of the write-back generator.
// The generator takes the slave side of this interface.
interface wb_bytemask_seq_if
  import wb_bytemask_seq_pkg::*;
#(
  parameter int CH_NUM       = DEF_CH_NUM,
  parameter int ACT_PER_ADDR = DEF_ACT_PER_ADDR,
  parameter int BW_PER_ACT   = DEF_BW_PER_ACT,
  parameter int ADDR_W       = DEF_ADDR_W
);

  localparam int CH_BITS  = $clog2(CH_NUM);
  localparam int ACT_BITS = $clog2(ACT_PER_ADDR);
  localparam int LANES    = CH_NUM * ACT_PER_ADDR;

  logic                          in_valid;
  logic [CH_BITS-1:0]            in_ch_idx;
  logic [ACT_BITS-1:0]           in_act_pos;
  logic [ADDR_W-1:0]             in_addr;
  logic [BW_PER_ACT-1:0]         in_data;

  logic                          sram_wen;
  logic [ADDR_W-1:0]             sram_waddr;
  logic [LANES-1:0]              sram_bytemask;
  logic [LANES*BW_PER_ACT-1:0]   sram_wdata;

  modport master (
    output in_valid, in_ch_idx, in_act_pos, in_addr, in_data,
    input  sram_wen, sram_waddr, sram_bytemask, sram_wdata
  );

  modport slave (
    input  in_valid, in_ch_idx, in_act_pos, in_addr, in_data,
    output sram_wen, sram_waddr, sram_bytemask, sram_wdata
  );

endinterface

// File: rtl/wb_lane_decode.sv
// Combinational lane decoder: places one activation into its lane of the SRAM
// word and clears the matching active-low mask bit.
module wb_lane_decode
  import wb_bytemask_seq_pkg::*;
#(
  parameter  int CH_NUM       = DEF_CH_NUM,
  parameter  int ACT_PER_ADDR = DEF_ACT_PER_ADDR,
  parameter  int BW_PER_ACT   = DEF_BW_PER_ACT,
  localparam int CH_BITS      = $clog2(CH_NUM),
  localparam int ACT_BITS     = $clog2(ACT_PER_ADDR),
  localparam int LANES        = CH_NUM * ACT_PER_ADDR
) (
  input  logic [CH_BITS-1:0]          ch,
  input  logic [ACT_BITS-1:0]         act_pos,
  input  logic [BW_PER_ACT-1:0]       data,
  output logic [LANES-1:0]            mask,
  output logic [LANES*BW_PER_ACT-1:0] wdata
);

  int mask_bit;

  // NOTE: combinational logic uses blocking assignments and gives every output a
  // default before any conditional write, so no latch can be inferred.
  always_comb begin
    mask     = '1;
    wdata    = '0;
    mask_bit = lane_to_mask_bit(int'(ch) * ACT_PER_ADDR + int'(act_pos), LANES);
    for (int i = 0; i < LANES; i++) begin
      if (i == mask_bit) begin
        mask[i]                               = 1'b0;
        wdata[i*BW_PER_ACT +: BW_PER_ACT]     = data;
      end
    end
  end

endmodule

// File: rtl/wb_bytemask_seq.sv
// Activation SRAM write-back generator: decodes one activation per cycle into a
// single-lane bytemask write and presents it LATENCY cycles later.
module wb_bytemask_seq
  import wb_bytemask_seq_pkg::*;
#(
  parameter int CH_NUM       = DEF_CH_NUM,
  parameter int ACT_PER_ADDR = DEF_ACT_PER_ADDR,
  parameter int BW_PER_ACT   = DEF_BW_PER_ACT,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LATENCY      = DEF_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             auto_mode,
  wb_bytemask_seq_if.slave bus,
  output logic             frame_done,
  output logic             err_range
);

  localparam int                 CH_BITS = $clog2(CH_NUM);
  localparam int                 LANES   = CH_NUM * ACT_PER_ADDR;
  localparam int                 DATA_W  = LANES * BW_PER_ACT;
  localparam logic [CH_BITS-1:0] CH_LAST = CH_BITS'(CH_NUM - 1);

  typedef struct packed {
    logic              valid;
    logic              frame_end;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] wdata;
  } stage_t;

  stage_t             pipe [LATENCY];
  logic [CH_BITS-1:0] ch_cnt;
  logic [CH_BITS-1:0] ch_eff;
  logic               ch_bad;
  logic               frame_end_tag;
  logic [LANES-1:0]   dec_mask;
  logic [DATA_W-1:0]  dec_wdata;

  // Out-of-range manual channels are folded onto channel 0 and flagged.
  always_comb begin
    ch_bad        = !auto_mode && (bus.in_ch_idx > CH_LAST);
    ch_eff        = auto_mode ? ch_cnt : (ch_bad ? '0 : bus.in_ch_idx);
    frame_end_tag = auto_mode && (ch_cnt == CH_LAST);
  end

  wb_lane_decode #(
    .CH_NUM       (CH_NUM),
    .ACT_PER_ADDR (ACT_PER_ADDR),
    .BW_PER_ACT   (BW_PER_ACT)
  ) u_lane_decode (
    .ch      (ch_eff),
    .act_pos (bus.in_act_pos),
    .data    (bus.in_data),
    .mask    (dec_mask),
    .wdata   (dec_wdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt    <= '0;
      err_range <= 1'b0;
    end else if (clear) begin
      ch_cnt    <= '0;
      err_range <= 1'b0;
    end else if (bus.in_valid) begin
      if (auto_mode) ch_cnt <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
      if (ch_bad)    err_range <= 1'b1;
    end
  end

  // Idle stages always carry the idle mask/data, so the last stage can drive the
  // SRAM port directly; addresses only advance behind valid beats.
  // NOTE: every pipeline stage is reset, not just the valids, because the output
  // stage must show the idle bytemask and zero data straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i].valid     <= 1'b0;
        pipe[i].frame_end <= 1'b0;
        pipe[i].addr      <= '0;
        pipe[i].mask      <= '1;
        pipe[i].wdata     <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i].valid     <= 1'b0;
        pipe[i].frame_end <= 1'b0;
        pipe[i].mask      <= '1;
        pipe[i].wdata     <= '0;
      end
    end else begin
      pipe[0].valid     <= bus.in_valid;
      pipe[0].frame_end <= bus.in_valid && frame_end_tag;
      pipe[0].mask      <= bus.in_valid ? dec_mask : '1;
      pipe[0].wdata     <= bus.in_valid ? dec_wdata : '0;
      if (bus.in_valid) pipe[0].addr <= bus.in_addr;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i].valid     <= pipe[i-1].valid;
        pipe[i].frame_end <= pipe[i-1].frame_end;
        pipe[i].mask      <= pipe[i-1].mask;
        pipe[i].wdata     <= pipe[i-1].wdata;
        if (pipe[i-1].valid) pipe[i].addr <= pipe[i-1].addr;
      end
    end
  end

  assign bus.sram_wen      = ~pipe[LATENCY-1].valid;
  assign bus.sram_waddr    = pipe[LATENCY-1].addr;
  assign bus.sram_bytemask = pipe[LATENCY-1].mask;
  assign bus.sram_wdata    = pipe[LATENCY-1].wdata;
  assign frame_done        = pipe[LATENCY-1].frame_end;

endmodule
